// File: rtl/field_packer_pkg.sv
// rtl/field_packer_pkg.sv - shared FSM type and width/length helpers for field_packer
package field_packer_pkg;

   // ACC: accepting fields; FLUSH: one cycle spent emitting the partial word
   typedef enum logic {
      ACC   = 1'b0,
      FLUSH = 1'b1
   } state_e;

   // width of a port able to carry lengths 0..field_w
   function automatic int calc_len_w(input int field_w);
      return $clog2(field_w + 1);
   endfunction

   // width of a fill counter able to carry 0..out_w
   function automatic int calc_fill_w(input int out_w);
      return $clog2(out_w + 1);
   endfunction

   // oversize lengths are treated as a full-width field
   function automatic int clamp_len(input int len, input int field_w);
      return (len > field_w) ? field_w : len;
   endfunction

endpackage

// File: rtl/field_packer_merge.sv
// rtl/field_packer_merge.sv - combinational append of one field to the left-justified accumulator
module field_packer_merge
   import field_packer_pkg::*;
#(
   parameter int  OUT_W   = 8,
   parameter int  FIELD_W = 4,
   localparam int LEN_W   = calc_len_w(FIELD_W),
   localparam int FILL_W  = calc_fill_w(OUT_W)
) (
   input  logic [OUT_W-1:0]   acc_i,
   input  logic [FILL_W-1:0]  fill_i,
   input  logic [FIELD_W-1:0] data_i,
   input  logic [LEN_W-1:0]   len_i,
   output logic [OUT_W-1:0]   acc_o,
   output logic [FILL_W-1:0]  fill_o,
   output logic [OUT_W-1:0]   word_o,
   output logic               complete_o
);

   localparam int                 WIDE_W = OUT_W + FIELD_W;
   localparam logic [FIELD_W-1:0] ONES   = '1;

   logic [FIELD_W-1:0] mask;
   logic [FIELD_W-1:0] bits;
   logic [WIDE_W-1:0]  wide;
   logic [OUT_W-1:0]   tail;
   int                 sum;

   // the accumulator is kept MSB-aligned; the field lands right below the last valid bit
   // in a window one field wider than a word, so overflow bits sit in the low FIELD_W bits
   always_comb begin
      mask       = ~(ONES << len_i);
      bits       = data_i & mask;
      sum        = int'(fill_i) + int'(len_i);
      wide       = {acc_i, {FIELD_W{1'b0}}} | (WIDE_W'(bits) << (WIDE_W - sum));
      word_o     = wide[WIDE_W-1 -: OUT_W];
      tail       = OUT_W'(wide[FIELD_W-1:0]) << (OUT_W - FIELD_W);
      complete_o = (sum >= OUT_W);
      if (complete_o) begin
         acc_o  = tail;
         fill_o = FILL_W'(sum - OUT_W);
      end else begin
         acc_o  = word_o;
         fill_o = FILL_W'(sum);
      end
   end

endmodule

// File: rtl/field_packer.sv
// rtl/field_packer.sv - MSB-first field packer with flush; FIELD_PACKER_INV_EN adds in_inv/inv_count
module field_packer
   import field_packer_pkg::*;
#(
   parameter int  OUT_W   = 8,
   parameter int  FIELD_W = 4,
   localparam int LEN_W   = calc_len_w(FIELD_W),
   localparam int FILL_W  = calc_fill_w(OUT_W)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [FIELD_W-1:0] in_data,
   input  logic [LEN_W-1:0]   in_len,
`ifdef FIELD_PACKER_INV_EN
   input  logic               in_inv,
   output logic [15:0]        inv_count,
`endif
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_data,
   output logic [FILL_W-1:0]  out_fill,
   output logic               out_last,
   output logic               busy
);

   state_e             state_q, state_d;
   logic [OUT_W-1:0]   acc_q, acc_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic               flush_pend_q, flush_pend_d;
   logic               out_valid_q, out_valid_d;
   logic [OUT_W-1:0]   out_data_q, out_data_d;
   logic [FILL_W-1:0]  out_fill_q, out_fill_d;
   logic               out_last_q, out_last_d;

   logic               slot_free;
   logic               accept;
   logic [LEN_W-1:0]   len_c;
   logic [FIELD_W-1:0] data_eff;
   logic [OUT_W-1:0]   m_acc;
   logic [OUT_W-1:0]   m_word;
   logic [FILL_W-1:0]  m_fill;
   logic               m_complete;

   assign len_c = LEN_W'(clamp_len(int'(in_len), FIELD_W));

`ifdef FIELD_PACKER_INV_EN
   assign data_eff = in_inv ? ~in_data : in_data;
`else
   assign data_eff = in_data;
`endif

   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = slot_free && !flush_pend_q && (state_q == ACC);
   assign accept    = in_valid && in_ready;

   field_packer_merge #(
      .OUT_W   (OUT_W),
      .FIELD_W (FIELD_W)
   ) u_merge (
      .acc_i      (acc_q),
      .fill_i     (fill_q),
      .data_i     (data_eff),
      .len_i      (len_c),
      .acc_o      (m_acc),
      .fill_o     (m_fill),
      .word_o     (m_word),
      .complete_o (m_complete)
   );

   // next-state for the accumulator, output slot, pending flush and FSM
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      fill_d       = fill_q;
      flush_pend_d = flush_pend_q;
      out_valid_d  = out_valid_q && !out_ready;
      out_data_d   = out_data_q;
      out_fill_d   = out_fill_q;
      out_last_d   = out_last_q;

      if (flush && !flush_pend_q) begin
         flush_pend_d = 1'b1;
      end

      if (accept) begin
         acc_d  = m_acc;
         fill_d = m_fill;
         if (m_complete) begin
            out_valid_d = 1'b1;
            out_data_d  = m_word;
            out_fill_d  = FILL_W'(OUT_W);
            out_last_d  = 1'b0;
         end
      end

      case (state_q)
         ACC: begin
            if (flush_pend_q && slot_free) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            // slot is guaranteed empty here: nothing was pushed while the flush was pending
            if (fill_q != '0) begin
               out_valid_d = 1'b1;
               out_data_d  = acc_q;
               out_fill_d  = fill_q;
               out_last_d  = 1'b1;
            end
            acc_d        = '0;
            fill_d       = '0;
            flush_pend_d = 1'b0;
            state_d      = ACC;
         end
         default: state_d = ACC;
      endcase
   end

   // state registers; reset discards any partially packed bits immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ACC;
         acc_q        <= '0;
         fill_q       <= '0;
         flush_pend_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_fill_q   <= '0;
         out_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         fill_q       <= fill_d;
         flush_pend_q <= flush_pend_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_fill_q   <= out_fill_d;
         out_last_q   <= out_last_d;
      end
   end

`ifdef FIELD_PACKER_INV_EN
   logic [15:0] inv_count_q, inv_count_d;

   // saturating count of accepted fields that were inverted
   always_comb begin
      inv_count_d = inv_count_q;
      if (accept && in_inv && (inv_count_q != 16'hFFFF)) begin
         inv_count_d = inv_count_q + 16'd1;
      end
   end

   // inversion counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inv_count_q <= '0;
      end else begin
         inv_count_q <= inv_count_d;
      end
   end

   assign inv_count = inv_count_q;
`endif

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_fill  = out_fill_q;
   assign out_last  = out_last_q;
   assign busy      = flush_pend_q || (fill_q != '0) || (state_q == FLUSH);

endmodule

// File: tb/tb_field_packer.sv
// tb/tb_field_packer.sv - directed and randomized bench for field_packer against a bit-queue model
`timescale 1ns/1ps
module tb_field_packer;

   localparam int OUT_W   = 8;
   localparam int FIELD_W = 4;
   localparam int LEN_W   = 3;
   localparam int FILL_W  = 4;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [FIELD_W-1:0] in_data;
   logic [LEN_W-1:0]   in_len;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [OUT_W-1:0]   out_data;
   logic [FILL_W-1:0]  out_fill;
   logic               out_last;
   logic               busy;
`ifdef FIELD_PACKER_INV_EN
   logic               in_inv;
   logic [15:0]        inv_count;
`endif

   int total = 0;
   int bad   = 0;

   field_packer #(
      .OUT_W   (OUT_W),
      .FIELD_W (FIELD_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_len    (in_len),
`ifdef FIELD_PACKER_INV_EN
      .in_inv    (in_inv),
      .inv_count (inv_count),
`endif
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_fill  (out_fill),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: a queue of packed bits in arrival order plus the one-word output slot
   bit               mq[$];
   bit               m_ov;
   bit               m_last;
   bit               m_pend;
   bit               m_flushing;
   logic [OUT_W-1:0] m_data;
   int               m_fill;
   int               m_inv;

   function automatic logic [OUT_W-1:0] take(input int n);
      logic [OUT_W-1:0] w;
      w = '0;
      for (int i = 0; i < n; i++) w[OUT_W-1-i] = mq.pop_front();
      return w;
   endfunction

   always @(posedge clk or posedge rst) begin
      bit               sf, rdy, acc, was_pend;
      int               l;
      logic [FIELD_W-1:0] d;
      if (rst) begin
         mq.delete();
         m_ov = 0; m_last = 0; m_pend = 0; m_flushing = 0; m_inv = 0; m_fill = 0; m_data = '0;
      end else begin
         sf       = !m_ov || out_ready;
         rdy      = sf && !m_pend && !m_flushing;
         acc      = in_valid && rdy;
         was_pend = m_pend;
         if (m_ov && out_ready) m_ov = 0;
         if (acc) begin
            l = (int'(in_len) > FIELD_W) ? FIELD_W : int'(in_len);
            d = in_data;
`ifdef FIELD_PACKER_INV_EN
            if (in_inv) begin
               d = ~d;
               if (m_inv < 65535) m_inv++;
            end
`endif
            for (int i = l - 1; i >= 0; i--) mq.push_back(d[i]);
            if (mq.size() >= OUT_W) begin
               m_data = take(OUT_W); m_fill = OUT_W; m_last = 0; m_ov = 1;
            end
         end
         if (m_flushing) begin
            if (mq.size() > 0) begin
               m_fill = mq.size(); m_data = take(m_fill); m_last = 1; m_ov = 1;
            end
            m_flushing = 0;
            m_pend     = 0;
         end else if (was_pend && sf) begin
            m_flushing = 1;
         end
         if (flush && !was_pend) m_pend = 1;
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         check("in_ready", in_ready, (!m_ov || out_ready) && !m_pend && !m_flushing);
         check("out_valid", out_valid, m_ov);
         check("busy", busy, m_pend || (mq.size() != 0) || m_flushing);
         if (m_ov) begin
            check("out_data", out_data, m_data);
            check("out_fill", out_fill, m_fill);
            check("out_last", out_last, m_last);
         end
`ifdef FIELD_PACKER_INV_EN
         check("inv_count", inv_count, m_inv);
`endif
      end
   end

   task automatic push(input logic [FIELD_W-1:0] d, input int l, input logic inv, input logic fl);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_len   = LEN_W'(l);
      flush    = fl;
`ifdef FIELD_PACKER_INV_EN
      in_inv   = inv;
`else
      if (inv) $display("note: inversion requested without FIELD_PACKER_INV_EN");
`endif
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("push_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      flush    = 1'b0;
`ifdef FIELD_PACKER_INV_EN
      in_inv   = 1'b0;
`endif
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("wait_out", out_valid, 1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_len = '0; flush = 1'b0; out_ready = 1'b1;
`ifdef FIELD_PACKER_INV_EN
      in_inv = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_fill", out_fill, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);

      // 1101 01 1 1 -> D7, one cycle after the last accept
      push(4'hD, 4, 0, 0);
      push(4'h1, 2, 0, 0);
`ifdef FIELD_PACKER_INV_EN
      push(4'h0, 1, 1, 0);
`else
      push(4'h1, 1, 0, 0);
`endif
      push(4'h1, 1, 0, 0);
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, 8'hD7);
      check("t1_fill", out_fill, 8);
      check("t1_last", out_last, 0);
`ifdef FIELD_PACKER_INV_EN
      check("t1_inv_count", inv_count, 1);
`endif

      // 111 x3 -> FF with one bit left over, flush -> 80/1/last
      push(4'h7, 3, 0, 0);
      push(4'h7, 3, 0, 0);
      push(4'h7, 3, 0, 0);
      check("t2_valid", out_valid, 1);
      check("t2_data", out_data, 8'hFF);
      check("t2_fill", out_fill, 8);
      pulse_flush();
      wait_out();
      check("t2_flush_data", out_data, 8'h80);
      check("t2_flush_fill", out_fill, 1);
      check("t2_flush_last", out_last, 1);
      check("t2_busy", busy, 0);

      // backpressure: word held stable, inputs stalled
      @(posedge clk); #1;
      out_ready = 1'b0;
      push(4'hA, 4, 0, 0);
      push(4'h5, 4, 0, 0);
      for (int i = 0; i < 5; i++) begin
         check("t3_in_ready", in_ready, 0);
         check("t3_hold_data", out_data, 8'hA5);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("t3_popped", out_valid, 0);
      check("t3_in_ready_back", in_ready, 1);

      // flush together with the completing field: only the full word
      push(4'h3, 4, 0, 0);
      push(4'hA, 4, 0, 1);
      check("t4_data", out_data, 8'h3A);
      check("t4_last", out_last, 0);
      repeat (4) begin @(posedge clk); #1; end
      check("t4_no_extra", out_valid, 0);
      check("t4_busy", busy, 0);

      // length clamp and zero-length no-op: 1001 + 0110 -> 96
      push(4'h9, 7, 0, 0);
      push(4'h6, 0, 0, 0);
      push(4'h6, 4, 0, 0);
      check("t6_data", out_data, 8'h96);

      // reset mid-word
      push(4'hF, 4, 0, 0);
      push(4'h1, 1, 0, 0);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_valid", out_valid, 0);
      check("t5_rst_busy", busy, 0);
      @(posedge clk); #1 rst = 1'b0;
      push(4'hF, 4, 0, 0);
      pulse_flush();
      wait_out();
      check("t5_data", out_data, 8'hF0);
      check("t5_fill", out_fill, 4);
      check("t5_last", out_last, 1);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = FIELD_W'($urandom);
         in_len    = LEN_W'($urandom_range(0, 7));
         flush     = ($urandom_range(0, 15) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef FIELD_PACKER_INV_EN
         in_inv    = 1'($urandom_range(0, 1));
`endif
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      pulse_flush();
      repeat (10) begin @(posedge clk); #1; end
      check("drain_busy", busy, 0);
      check("drain_valid", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/field_packer.md
Name: field_packer

Overview:
- Sequential, parametrised successor to the fixed-layout 8-bit concatenation packer.
- Accepts a stream of variable-length bit fields and packs them MSB-first into OUT_W-bit words.
- Emits each word over a valid/ready handshake; a flush request emits a partial final word.
- Sits between field producers (header/record builders) and word-wide sinks such as FIFOs or bus writers.

Parameters:
OUT_W, 8, output word width in bits (>= FIELD_W)
FIELD_W, 4, maximum field width in bits (>= 1)
LEN_W, $clog2(FIELD_W+1), width of the field length port (localparam-derived, not overridable)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  field present
in_ready  output  1  field accepted when in_valid && in_ready
in_data  input  FIELD_W  field bits, right-justified; only in_data[in_len-1:0] used
in_len  input  LEN_W  field length 0..FIELD_W; 0 = accepted no-op; >FIELD_W clamped to FIELD_W
flush  input  1  single-cycle request to emit the partial word
out_valid  output  1  word present
out_ready  input  1  word consumed when out_valid && out_ready
out_data  output  OUT_W  packed word; first-packed bit at MSB
out_fill  output  $clog2(OUT_W+1)  number of valid bits in out_data (OUT_W for full words)
out_last  output  1  word was produced by a flush
busy  output  1  flush pending or accumulator non-empty

Behaviour:
- Reset (async, rst=1): acc=0, fill=0, out_valid=0, out_data=0, out_fill=0, out_last=0, flush_pend=0, state=ACC. The accumulator and output register clear immediately, including mid-word; partially packed bits are discarded.
- Output slot free: slot_free = !out_valid || out_ready.
- in_ready = slot_free && !flush_pend && state==ACC (combinational).
- Accept, with fill+len < OUT_W: field bits are appended below the existing bits (MSB-first). fill += len. No word is produced.
- Accept, with fill+len >= OUT_W: the upper OUT_W-fill field bits complete the word.
  - Next cycle: out_valid=1, out_fill=OUT_W, out_last=0.
  - The remaining fill+len-OUT_W bits become the new accumulator head; fill = fill+len-OUT_W.
  - Latency from accepting the completing field to out_valid is 1 cycle.
- A word held while out_ready=0 keeps out_data/out_fill/out_last stable. A completing push and a pop in the same cycle give back-to-back words at full throughput.
- flush sets flush_pend, even if a field is accepted in the same cycle; that field is packed first. flush while flush_pend=1 is ignored (no counting).
- FSM:
  - ACC -> FLUSH when flush_pend && slot_free.
  - FLUSH, with fill>0: emits a word with out_data = acc bits left-justified and zero-padded in the LSBs, out_fill=fill, out_last=1. fill=0, flush_pend=0. -> ACC.
  - FLUSH, with fill==0: no word is emitted, flush_pend=0. -> ACC.
- An exact word boundary (fill==0 after a completing push) followed by flush emits no extra word.
- busy = flush_pend || fill!=0 || state==FLUSH.

Optional Feature:
- Macro FIELD_PACKER_INV_EN.
- Defined:
  - Adds input in_inv (1 bit). When set on an accepted field, in_data[in_len-1:0] is bitwise inverted before packing.
  - Adds output inv_count (16 bits, saturating) that counts accepted inverted fields. Reset value is 0.
- Undefined: neither port exists, and fields are packed unmodified.

Decomposition:
- Package field_packer_pkg holds:
  - the FSM enum (ACC, FLUSH);
  - LEN_W and FILL_W derivation functions;
  - the clamp-length function.
- One sub-module, field_packer_merge (combinational), computes next acc/fill and the completed word from acc, fill, data and len. The top level keeps the registers, handshake and FSM.

Test Plan:
- OUT_W=8, FIELD_W=4; push 1101/len4, 01/len2, 1/len1, 1/len1 -> one word out_data=8'hD7, out_fill=8, out_last=0, 1 cycle after the last accept.
- Same fields with FIELD_PACKER_INV_EN, third field 0/len1 with in_inv=1 -> 8'hD7, inv_count=1.
- Push 111/len3 three times with out_ready=1 -> word 8'hFF (fill 8), residual fill=1; then flush -> out_data=8'h80, out_fill=1, out_last=1, busy=0.
- Hold out_ready=0 with a word pending -> in_ready=0 and out_data stable for 5 cycles; release -> pop, then in_ready=1.
- flush in the same cycle as accepting 1010/len4 (fill=4 before) -> full word 8'h?A first, no flush word (fill 0), flush_pend clears.
- Assert rst mid-word (fill=5) -> out_valid=0, busy=0 immediately; next push 1111/len4 then flush -> out_data=8'hF0, out_fill=4.
